// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : router_fsm
//  Purpose  : Control state machine of a 1-to-3 packet router. Decodes the
//             destination from the header byte, then steps through header,
//             payload and parity loading. It stalls while the selected FIFO
//             is full and waits for a busy destination FIFO to drain.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   rising-edge clock
//    resetn         in   synchronous active-low reset
//    pkt_valid      in   header/payload on the bus (low on the parity byte)
//    datain[1:0]    in   destination address from the header (3 = invalid)
//    fifo_full      in   selected FIFO is full
//    empty0..2      in   per-FIFO empty flags
//    soft_reset0..2 in   per-destination timeout reset
//    parity_done    in   parity byte has been captured
//    low_pktvalid   in   pkt_valid fell while the FSM was stalled
//    we_reg         out  FIFO write enable
//    detect_addr    out  in DECODE_ADDRESS
//    ld_state       out  in LOAD_DATA
//    laf_state      out  in LOAD_AFTER_FULL
//    lfd_state      out  in LOAD_FIRST_DATA
//    full_state     out  in FIFO_FULL_STATE
//    rst_int_reg    out  in CHECK_PARITY_ERROR
//    busy           out  source must hold its data
// ============================================================================
module router_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] datain,
    input  logic       fifo_full,
    input  logic       empty0,
    input  logic       empty1,
    input  logic       empty2,
    input  logic       soft_reset0,
    input  logic       soft_reset1,
    input  logic       soft_reset2,
    input  logic       parity_done,
    input  logic       low_pktvalid,
    output logic       we_reg,
    output logic       detect_addr,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] c_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] c_LOAD_DATA          = 3'd2;
    localparam logic [2:0] c_LOAD_PARITY        = 3'd3;
    localparam logic [2:0] c_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] c_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] c_WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] c_CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_addr;

    logic       w_hdr_empty;   // empty flag of the port named by the header
    logic       w_hdr_valid;   // header carries a legal destination
    logic       w_addr_empty;  // empty flag of the latched destination
    logic       w_soft_hit;    // timeout reset aimed at the latched destination

    // ------------------------------------------------------------------
    // Per-port selections
    // ------------------------------------------------------------------
    always_comb begin
        w_hdr_empty = 1'b0;
        w_hdr_valid = 1'b1;
        case (datain)
            2'd0:    w_hdr_empty = empty0;
            2'd1:    w_hdr_empty = empty1;
            2'd2:    w_hdr_empty = empty2;
            default: w_hdr_valid = 1'b0;
        endcase
    end

    // Address 3 can be latched from an invalid header, but the FSM never
    // leaves DECODE_ADDRESS with it, so it selects nothing here.
    always_comb begin
        w_addr_empty = 1'b0;
        w_soft_hit   = 1'b0;
        case (r_addr)
            2'd0: begin
                w_addr_empty = empty0;
                w_soft_hit   = soft_reset0;
            end
            2'd1: begin
                w_addr_empty = empty1;
                w_soft_hit   = soft_reset1;
            end
            2'd2: begin
                w_addr_empty = empty2;
                w_soft_hit   = soft_reset2;
            end
            default: begin
                w_addr_empty = 1'b0;
                w_soft_hit   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            // The header byte is only on the bus while decoding.
            if (r_state == c_DECODE_ADDRESS) begin
                r_addr <= datain;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_DECODE_ADDRESS: begin
                if (pkt_valid && w_hdr_valid) begin
                    if (w_hdr_empty) begin
                        w_next_state = c_LOAD_FIRST_DATA;
                    end else begin
                        w_next_state = c_WAIT_TILL_EMPTY;
                    end
                end
            end
            // Unconditional states never look at an input, so undriven
            // bus values cannot steer them.
            c_LOAD_FIRST_DATA: w_next_state = c_LOAD_DATA;
            c_LOAD_DATA: begin
                // A full FIFO takes priority over the end of the payload;
                // the fall of pkt_valid is remembered as low_pktvalid.
                if (fifo_full) begin
                    w_next_state = c_FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    w_next_state = c_LOAD_PARITY;
                end
            end
            c_FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    w_next_state = c_LOAD_AFTER_FULL;
                end
            end
            c_LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    w_next_state = c_DECODE_ADDRESS;
                end else if (low_pktvalid) begin
                    w_next_state = c_LOAD_PARITY;
                end else begin
                    w_next_state = c_LOAD_DATA;
                end
            end
            c_LOAD_PARITY: w_next_state = c_CHECK_PARITY_ERROR;
            c_CHECK_PARITY_ERROR: begin
                if (fifo_full) begin
                    w_next_state = c_FIFO_FULL_STATE;
                end else begin
                    w_next_state = c_DECODE_ADDRESS;
                end
            end
            c_WAIT_TILL_EMPTY: begin
                if (w_addr_empty) begin
                    w_next_state = c_LOAD_FIRST_DATA;
                end
            end
            default: w_next_state = c_DECODE_ADDRESS;
        endcase

        // A timeout on the active destination abandons the packet from
        // any state.
        if (w_soft_hit) begin
            w_next_state = c_DECODE_ADDRESS;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign detect_addr = (r_state == c_DECODE_ADDRESS);
    assign lfd_state   = (r_state == c_LOAD_FIRST_DATA);
    assign ld_state    = (r_state == c_LOAD_DATA);
    assign laf_state   = (r_state == c_LOAD_AFTER_FULL);
    assign full_state  = (r_state == c_FIFO_FULL_STATE);
    assign rst_int_reg = (r_state == c_CHECK_PARITY_ERROR);
    assign we_reg      = (r_state == c_LOAD_DATA)
                       | (r_state == c_LOAD_PARITY)
                       | (r_state == c_LOAD_AFTER_FULL);
    // The source may only drive new bytes while idle or streaming payload.
    assign busy        = !((r_state == c_DECODE_ADDRESS) || (r_state == c_LOAD_DATA));

endmodule
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_fsm
//  Purpose  : Self-checking bench for router_fsm. Directed packet scenarios
//             followed by randomized traffic, compared against a
//             behavioural reference of the router control flow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm;

    logic       clk;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] datain;
    logic       fifo_full;
    logic       empty0, empty1, empty2;
    logic       soft_reset0, soft_reset1, soft_reset2;
    logic       parity_done;
    logic       low_pktvalid;
    logic       we_reg, detect_addr, ld_state, laf_state;
    logic       lfd_state, full_state, rst_int_reg, busy;

    router_fsm u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .datain       (datain),
        .fifo_full    (fifo_full),
        .empty0       (empty0),
        .empty1       (empty1),
        .empty2       (empty2),
        .soft_reset0  (soft_reset0),
        .soft_reset1  (soft_reset1),
        .soft_reset2  (soft_reset2),
        .parity_done  (parity_done),
        .low_pktvalid (low_pktvalid),
        .we_reg       (we_reg),
        .detect_addr  (detect_addr),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .lfd_state    (lfd_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phases of a packet, named after the router's states.
    typedef enum {M_DA, M_LFD, M_LD, M_LP, M_FULL, M_LAF, M_WTE, M_CPE} st_t;

    st_t        m_state;
    logic [1:0] m_addr;
    int         n_assert;
    int         n_fail;

    logic [7:0] w_obs;
    assign w_obs = {detect_addr, lfd_state, ld_state, laf_state,
                    full_state, rst_int_reg, we_reg, busy};

    // Expected output vector for a phase, in w_obs order.
    function automatic logic [7:0] exp_outs(input st_t s);
        logic we, bz;
        we = (s == M_LD) || (s == M_LP) || (s == M_LAF);
        bz = !((s == M_DA) || (s == M_LD));
        return {s == M_DA, s == M_LFD, s == M_LD, s == M_LAF,
                s == M_FULL, s == M_CPE, we, bz};
    endfunction

    function automatic st_t ref_next(input st_t s, input logic [1:0] a);
        logic [3:0] emp;
        logic [3:0] sr;
        emp = {1'b0, empty2, empty1, empty0};
        sr  = {1'b0, soft_reset2, soft_reset1, soft_reset0};
        if (sr[a]) return M_DA;
        case (s)
            M_DA:   if (pkt_valid && datain != 2'd3) return emp[datain] ? M_LFD : M_WTE;
                    else return M_DA;
            M_LFD:  return M_LD;
            M_LD:   return fifo_full ? M_FULL : (!pkt_valid ? M_LP : M_LD);
            M_FULL: return fifo_full ? M_FULL : M_LAF;
            M_LAF:  return parity_done ? M_DA : (low_pktvalid ? M_LP : M_LD);
            M_LP:   return M_CPE;
            M_CPE:  return fifo_full ? M_FULL : M_DA;
            M_WTE:  return emp[m_addr] ? M_LFD : M_WTE;
            default: return M_DA;
        endcase
    endfunction

    task automatic check(input string tag, input st_t want);
        n_assert++;
        assert (w_obs === exp_outs(want))
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp_outs(want));
        end
    endtask

    // Advance one clock: the reference consumes the same inputs the DUT
    // samples, and outputs are compared 1 time unit after the edge.
    task automatic tick(input string tag);
        st_t        nxt;
        logic [1:0] na;
        if (!resetn) begin
            nxt = M_DA;
            na  = 2'd0;
        end else begin
            nxt = ref_next(m_state, m_addr);
            na  = (m_state == M_DA) ? datain : m_addr;
        end
        @(posedge clk);
        m_state = nxt;
        m_addr  = na;
        #1;
        check({tag, "_model"}, m_state);
    endtask

    // Tick plus an independent, hand-derived expectation.
    task automatic step(input string tag, input st_t want);
        tick(tag);
        check(tag, want);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_state  = M_DA;
        m_addr   = 2'd0;
        resetn = 1'b0; pkt_valid = 1'b0; datain = 2'd0; fifo_full = 1'b0;
        empty0 = 1'b1; empty1 = 1'b1; empty2 = 1'b1;
        soft_reset0 = 1'b0; soft_reset1 = 1'b0; soft_reset2 = 1'b0;
        parity_done = 1'b0; low_pktvalid = 1'b0;

        // Reset and idle
        step("reset", M_DA);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", M_DA);

        // Normal packet to port 1
        pkt_valid = 1'b1; datain = 2'd1;
        step("p1_hdr", M_LFD);
        datain = 2'($urandom);
        for (int i = 0; i < 13; i++) step("p1_payload", M_LD);
        pkt_valid = 1'b0; parity_done = 1'b1;
        step("p1_parity", M_LP);
        parity_done = 1'b0;
        step("p1_check", M_CPE);
        step("p1_done", M_DA);

        // Full stall on port 0, return to payload, then low_pktvalid exit
        pkt_valid = 1'b1; datain = 2'd0;
        step("p0_hdr", M_LFD);
        step("p0_ld", M_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("p0_full", M_FULL);
        fifo_full = 1'b0;
        step("p0_laf", M_LAF);
        step("p0_back_ld", M_LD);
        fifo_full = 1'b1;
        step("p0_full2", M_FULL);
        fifo_full = 1'b0;
        step("p0_laf2", M_LAF);
        pkt_valid = 1'b0; low_pktvalid = 1'b1;
        step("p0_low_lp", M_LP);
        low_pktvalid = 1'b0;
        step("p0_cpe", M_CPE);
        fifo_full = 1'b1;
        step("cpe_full", M_FULL);
        fifo_full = 1'b0;
        step("cpe_laf", M_LAF);
        parity_done = 1'b1;
        step("laf_pdone", M_DA);
        parity_done = 1'b0;

        // fifo_full and pkt_valid low together: full wins
        pkt_valid = 1'b1; datain = 2'd2;
        step("sim_hdr", M_LFD);
        step("sim_ld", M_LD);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step("sim_full_wins", M_FULL);
        fifo_full = 1'b0;
        step("sim_laf", M_LAF);
        parity_done = 1'b1;
        step("sim_done", M_DA);
        parity_done = 1'b0;

        // Busy destination 2
        empty2 = 1'b0; pkt_valid = 1'b1; datain = 2'd2;
        step("wte_enter", M_WTE);
        for (int i = 0; i < 4; i++) step("wte_hold", M_WTE);
        empty2 = 1'b1;
        step("wte_exit", M_LFD);
        step("wte_ld", M_LD);
        pkt_valid = 1'b0;
        step("wte_lp", M_LP);
        step("wte_cpe", M_CPE);
        step("wte_da", M_DA);

        // Soft reset: non-addressed port ignored, addressed port aborts
        empty2 = 1'b0; pkt_valid = 1'b1; datain = 2'd2;
        step("sr_wte", M_WTE);
        soft_reset0 = 1'b1;
        step("sr0_ignored", M_WTE);
        soft_reset0 = 1'b0; soft_reset2 = 1'b1;
        step("sr2_abort", M_DA);
        soft_reset2 = 1'b0; empty2 = 1'b1; pkt_valid = 1'b0;
        step("sr_idle", M_DA);

        // Soft reset during payload
        pkt_valid = 1'b1; datain = 2'd1;
        step("sr1_hdr", M_LFD);
        step("sr1_ld", M_LD);
        soft_reset1 = 1'b1;
        step("sr1_abort", M_DA);
        soft_reset1 = 1'b0; pkt_valid = 1'b0;
        step("sr1_idle", M_DA);

        // Invalid address
        pkt_valid = 1'b1; datain = 2'd3;
        step("addr3_a", M_DA);
        step("addr3_b", M_DA);

        // Reset mid-packet
        datain = 2'd0;
        step("mr_hdr", M_LFD);
        step("mr_ld", M_LD);
        resetn = 1'b0;
        step("mr_reset", M_DA);
        resetn = 1'b1; pkt_valid = 1'b0;
        step("mr_idle", M_DA);

        // Randomized traffic against the reference
        for (int i = 0; i < 800; i++) begin
            resetn       = ($urandom_range(0, 49) != 0);
            pkt_valid    = ($urandom_range(0, 9) < 8);
            datain       = 2'($urandom);
            fifo_full    = ($urandom_range(0, 9) < 2);
            empty0       = ($urandom_range(0, 9) < 7);
            empty1       = ($urandom_range(0, 9) < 7);
            empty2       = ($urandom_range(0, 9) < 7);
            soft_reset0  = ($urandom_range(0, 39) == 0);
            soft_reset1  = ($urandom_range(0, 39) == 0);
            soft_reset2  = ($urandom_range(0, 39) == 0);
            parity_done  = ($urandom_range(0, 9) < 2);
            low_pktvalid = ($urandom_range(0, 9) < 2);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
